// File: rtl/rbus_vo_flip_ctrl_if.sv
// Ring-bus event port used by the video-out flip sequencer.
// The master drives the strobe, command, destination and argument; the slave returns the acknowledge.
interface rbus_vo_flip_ctrl_if;
  logic        eve_stb;
  logic [7:0]  eve_cmd;
  logic [7:0]  eve_dev;
  logic [39:0] eve_ptr;
  logic        eve_ack;

  modport master (output eve_stb, output eve_cmd, output eve_dev, output eve_ptr, input eve_ack);
  modport slave  (input eve_stb, input eve_cmd, input eve_dev, input eve_ptr, output eve_ack);
endinterface

// File: rtl/rbus_vo_flip_ctrl.sv
// Video-out configuration and double-buffer page-flip sequencer.
// Issues the init event sequence on start, then alternates base-address events between two buffers.
module rbus_vo_flip_ctrl #(
  parameter logic [7:0]  EVE_DEV     = 8'h00,
  parameter logic [38:0] BUF0_ADDR   = 39'h000000000,
  parameter logic [38:0] BUF1_ADDR   = 39'h000100000,
  parameter logic [15:0] PH_WIDTH    = 16'd2048,
  parameter logic [15:0] LO_WIDTH    = 16'd480,
  parameter logic [15:0] LO_HEIGHT   = 16'd272,
  parameter logic [1:0]  MODE        = 2'b00,
  parameter logic        H_POL       = 1'b0,
  parameter logic        V_POL       = 1'b0,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      soft_rst,
  input  logic                      start,
  input  logic                      flip_req,
  output logic                      flip_ack,
  output logic                      busy,
  output logic                      front_buf,
  output logic [38:0]               back_addr,
  output logic                      err,
  rbus_vo_flip_ctrl_if.master       eve
);

  typedef enum logic [2:0] {IDLE, INIT, READY, FLIP, ERR} state_t;

  state_t      state, state_d;
  logic        stb, stb_d;
  logic [7:0]  cmd, cmd_d;
  logic [39:0] ptr, ptr_d;
  logic [2:0]  step, step_d;
  logic [7:0]  cnt, cnt_d, cnt_inc;
  logic        pend, pend_d;
  logic        front_d, err_d, flip_ack_d, busy_d;
  logic        accept, timeout, restart;

  function automatic logic [7:0] init_cmd(input logic [2:0] s);
    case (s)
      3'd0:    return 8'h21;
      3'd1:    return 8'h22;
      3'd2:    return 8'h23;
      3'd3:    return 8'h24;
      3'd4:    return 8'h27;
      3'd5:    return 8'h28;
      3'd6:    return 8'h25;
      default: return 8'h20;
    endcase
  endfunction

  function automatic logic [39:0] init_ptr(input logic [2:0] s);
    case (s)
      3'd0:    return {24'd0, PH_WIDTH};
      3'd1:    return {24'd0, LO_WIDTH};
      3'd2:    return {24'd0, LO_HEIGHT};
      3'd3:    return {38'd0, MODE};
      3'd4:    return {39'd0, H_POL};
      3'd5:    return {39'd0, V_POL};
      3'd6:    return 40'd0;
      default: return {1'b0, BUF0_ADDR};
    endcase
  endfunction

  assign back_addr   = front_buf ? BUF0_ADDR : BUF1_ADDR;
  assign eve.eve_stb = stb;
  assign eve.eve_cmd = cmd;
  assign eve.eve_ptr = ptr;
  assign eve.eve_dev = EVE_DEV;

  always_comb begin
    state_d    = state;
    stb_d      = stb;
    cmd_d      = cmd;
    ptr_d      = ptr;
    step_d     = step;
    cnt_d      = cnt;
    pend_d     = pend;
    front_d    = front_buf;
    err_d      = err;
    flip_ack_d = 1'b0;
    restart    = 1'b0;
    cnt_inc    = cnt + 8'd1;
    accept     = stb & eve.eve_ack;
    timeout    = stb & ~eve.eve_ack & (cnt_inc == ACK_TIMEOUT);

    if (flip_req && (state != IDLE) && (state != ERR)) pend_d = 1'b1;
    if (stb && !eve.eve_ack) cnt_d = cnt_inc;
    if (accept) cnt_d = 8'd0;

    // A strobe left waiting too long is abandoned; only start or reset leaves ERR.
    if (timeout) begin
      stb_d   = 1'b0;
      err_d   = 1'b1;
      cnt_d   = 8'd0;
      state_d = ERR;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_d = INIT;
            step_d  = 3'd0;
          end
        end
        INIT: begin
          if (accept) begin
            stb_d = 1'b0;
            if (step == 3'd7) begin
              state_d = READY;
              front_d = 1'b0;
            end else begin
              step_d = step + 3'd1;
            end
          end else if (!stb) begin
            stb_d = 1'b1;
            cmd_d = init_cmd(step);
            ptr_d = init_ptr(step);
          end
        end
        READY: begin
          if (start) restart = 1'b1;
          else if (pend) state_d = FLIP;
        end
        FLIP: begin
          if (accept) begin
            stb_d      = 1'b0;
            front_d    = ~front_buf;
            flip_ack_d = 1'b1;
            pend_d     = flip_req;
            state_d    = READY;
          end else if (!stb) begin
            stb_d = 1'b1;
            cmd_d = 8'h20;
            ptr_d = {1'b0, back_addr};
          end
        end
        ERR: begin
          if (start) restart = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (restart) begin
      state_d = INIT;
      step_d  = 3'd0;
      err_d   = 1'b0;
      pend_d  = 1'b0;
      front_d = 1'b0;
    end

    busy_d = (state_d == IDLE) || (state_d == INIT) || (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      state     <= IDLE;
      stb       <= 1'b0;
      cmd       <= 8'd0;
      ptr       <= 40'd0;
      step      <= 3'd0;
      cnt       <= 8'd0;
      pend      <= 1'b0;
      front_buf <= 1'b0;
      err       <= 1'b0;
      flip_ack  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_d;
      stb       <= stb_d;
      cmd       <= cmd_d;
      ptr       <= ptr_d;
      step      <= step_d;
      cnt       <= cnt_d;
      pend      <= pend_d;
      front_buf <= front_d;
      err       <= err_d;
      flip_ack  <= flip_ack_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_rbus_vo_flip_ctrl.sv
// Directed bench for the video-out flip sequencer: init order/timing, flips, delayed ack,
// ack timeout, flips merged during init and soft reset during a pending flip.
module tb_rbus_vo_flip_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1, soft_rst = 1'b0, start = 1'b0, flip_req = 1'b0;
  logic        flip_ack, busy, front_buf, err;
  logic [38:0] back_addr;
  int          ack_mode = 3;
  logic        ack_dly = 1'b0;
  int          wcnt = 0;
  int          n_tests = 0, n_fail = 0;
  logic [7:0]  ev_cmd[$];
  logic [39:0] ev_ptr[$];
  int          n_fack = 0, stab_err = 0, gap_err = 0;
  logic        p_wait = 1'b0, p_acc = 1'b0, p_rst = 1'b1;
  logic [7:0]  p_cmd = '0;
  logic [39:0] p_ptr = '0;
  logic [7:0]  init_cmds [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h27, 8'h28, 8'h25, 8'h20};
  logic [39:0] init_ptrs [8] = '{40'd2048, 40'd480, 40'd272, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0};

  rbus_vo_flip_ctrl_if bus();
  // ack modes: 0 tied to strobe, 1 delayed, 2 never, 3 constantly high
  assign bus.eve_ack = (ack_mode == 0) ? bus.eve_stb : (ack_mode == 1) ? ack_dly : (ack_mode == 3);

  rbus_vo_flip_ctrl dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .start(start), .flip_req(flip_req),
    .flip_ack(flip_ack), .busy(busy), .front_buf(front_buf), .back_addr(back_addr),
    .err(err), .eve(bus.master)
  );

  always #5 clk = ~clk;

  // Delayed acknowledge: five waiting cycles, then ack in the sixth strobe cycle.
  always @(posedge clk) begin
    #1;
    if (ack_mode != 1) begin
      ack_dly = 1'b0; wcnt = 0;
    end else if (ack_dly) begin
      ack_dly = 1'b0; wcnt = 0;
    end else if (bus.eve_stb) begin
      wcnt++;
      if (wcnt == 6) ack_dly = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (p_wait && !p_rst && !rst && !soft_rst && !err &&
        (bus.eve_stb !== 1'b1 || bus.eve_cmd !== p_cmd || bus.eve_ptr !== p_ptr)) stab_err++;
    if (p_acc && !p_rst && bus.eve_stb) gap_err++;
    if (bus.eve_stb && bus.eve_ack) begin
      ev_cmd.push_back(bus.eve_cmd);
      ev_ptr.push_back(bus.eve_ptr);
    end
    if (flip_ack) n_fack++;
    p_wait = bus.eve_stb && !bus.eve_ack;
    p_acc  = bus.eve_stb && bus.eve_ack;
    p_rst  = rst || soft_rst;
    p_cmd  = bus.eve_cmd;
    p_ptr  = bus.eve_ptr;
  end

  task automatic test_reset();
    int n0;
    ack_mode = 3; rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.eve_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %0h want 0", bus.eve_stb); end
    n_tests++; if (bus.eve_cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd got %0h want 0", bus.eve_cmd); end
    n_tests++; if (bus.eve_ptr !== 40'h0) begin n_fail++; $display("FAIL reset_ptr got %0h want 0", bus.eve_ptr); end
    n_tests++; if (bus.eve_dev !== 8'h00) begin n_fail++; $display("FAIL reset_dev got %0h want 0", bus.eve_dev); end
    n_tests++; if (flip_ack !== 1'b0) begin n_fail++; $display("FAIL reset_flip_ack got %0h want 0", flip_ack); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0h want 0", err); end
    n_tests++; if (front_buf !== 1'b0) begin n_fail++; $display("FAIL reset_front got %0h want 0", front_buf); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %0h want 1", busy); end
    n_tests++; if (back_addr !== 39'h100000) begin n_fail++; $display("FAIL reset_back_addr got %0h want 100000", back_addr); end
    n0 = ev_cmd.size();
    rst = 1'b0; flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (ev_cmd.size() !== n0) begin n_fail++; $display("FAIL idle_no_event got %0d want %0d", ev_cmd.size(), n0); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_busy got %0h want 1", busy); end
  endtask

  task automatic test_init();
    logic [16:0] obs_stb, obs_busy;
    int n0, s0, g0;
    ack_mode = 0; n0 = ev_cmd.size(); s0 = stab_err; g0 = gap_err;
    obs_stb = '0; obs_busy = '0;
    start = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      obs_stb[k] = bus.eve_stb; obs_busy[k] = busy;
    end
    n_tests++; if (obs_stb !== 17'h0AAAA) begin n_fail++; $display("FAIL init_stb_timing got %05h want 0aaaa", obs_stb); end
    n_tests++; if (obs_busy !== 17'h0FFFF) begin n_fail++; $display("FAIL init_busy_timing got %05h want 0ffff", obs_busy); end
    n_tests++; if (ev_cmd.size() !== n0 + 8) begin n_fail++; $display("FAIL init_event_count got %0d want %0d", ev_cmd.size() - n0, 8); end
    if (ev_cmd.size() >= n0 + 8) begin
      for (int i = 0; i < 8; i++) begin
        n_tests++; if (ev_cmd[n0+i] !== init_cmds[i]) begin n_fail++; $display("FAIL init_cmd[%0d] got %0h want %0h", i, ev_cmd[n0+i], init_cmds[i]); end
        n_tests++; if (ev_ptr[n0+i] !== init_ptrs[i]) begin n_fail++; $display("FAIL init_ptr[%0d] got %0h want %0h", i, ev_ptr[n0+i], init_ptrs[i]); end
      end
    end
    repeat (4) @(negedge clk);
    n_tests++; if (ev_cmd.size() !== n0 + 8) begin n_fail++; $display("FAIL init_no_stale_flip got %0d want 8", ev_cmd.size() - n0); end
    n_tests++; if (front_buf !== 1'b0) begin n_fail++; $display("FAIL init_front got %0h want 0", front_buf); end
    n_tests++; if (gap_err !== g0) begin n_fail++; $display("FAIL init_gap got %0d want %0d", gap_err, g0); end
    n_tests++; if (stab_err !== s0) begin n_fail++; $display("FAIL init_stable got %0d want %0d", stab_err, s0); end
  endtask

  task automatic test_flips();
    logic [9:0] ob_stb, ob_fa, ob_fb;
    logic [39:0] exp_p [3] = '{40'h100000, 40'h0, 40'h100000};
    int n0, f0;
    ack_mode = 0; n0 = ev_cmd.size(); f0 = n_fack;
    ob_stb = '0; ob_fa = '0; ob_fb = '0;
    for (int p = 0; p < 3; p++) begin
      flip_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        flip_req = 1'b0;
        if (p == 0) begin ob_stb[k] = bus.eve_stb; ob_fa[k] = flip_ack; ob_fb[k] = front_buf; end
      end
    end
    n_tests++; if (ob_stb !== 10'h004) begin n_fail++; $display("FAIL flip_stb_timing got %03h want 004", ob_stb); end
    n_tests++; if (ob_fa !== 10'h008) begin n_fail++; $display("FAIL flip_ack_timing got %03h want 008", ob_fa); end
    n_tests++; if (ob_fb !== 10'h3F8) begin n_fail++; $display("FAIL flip_front_timing got %03h want 3f8", ob_fb); end
    n_tests++; if (n_fack - f0 !== 3) begin n_fail++; $display("FAIL flip_ack_count got %0d want 3", n_fack - f0); end
    n_tests++; if (ev_cmd.size() !== n0 + 3) begin n_fail++; $display("FAIL flip_event_count got %0d want 3", ev_cmd.size() - n0); end
    if (ev_cmd.size() >= n0 + 3) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (ev_cmd[n0+i] !== 8'h20) begin n_fail++; $display("FAIL flip_cmd[%0d] got %0h want 20", i, ev_cmd[n0+i]); end
        n_tests++; if (ev_ptr[n0+i] !== exp_p[i]) begin n_fail++; $display("FAIL flip_ptr[%0d] got %0h want %0h", i, ev_ptr[n0+i], exp_p[i]); end
      end
    end
    n_tests++; if (front_buf !== 1'b1) begin n_fail++; $display("FAIL flip_final_front got %0h want 1", front_buf); end
    n_tests++; if (back_addr !== 39'h0) begin n_fail++; $display("FAIL flip_final_back got %0h want 0", back_addr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ob_stb, ob_fa;
    int n0, f0;
    ack_mode = 0; n0 = ev_cmd.size(); f0 = n_fack;
    ob_stb = '0; ob_fa = '0;
    flip_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      flip_req = (k == 2);
      ob_stb[k] = bus.eve_stb; ob_fa[k] = flip_ack;
    end
    flip_req = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (ob_stb !== 8'h24) begin n_fail++; $display("FAIL b2b_stb_timing got %02h want 24", ob_stb); end
    n_tests++; if (ob_fa !== 8'h48) begin n_fail++; $display("FAIL b2b_ack_timing got %02h want 48", ob_fa); end
    n_tests++; if (ev_cmd.size() !== n0 + 2) begin n_fail++; $display("FAIL b2b_event_count got %0d want 2", ev_cmd.size() - n0); end
    if (ev_cmd.size() >= n0 + 2) begin
      n_tests++; if (ev_ptr[n0] !== 40'h0) begin n_fail++; $display("FAIL b2b_ptr0 got %0h want 0", ev_ptr[n0]); end
      n_tests++; if (ev_ptr[n0+1] !== 40'h100000) begin n_fail++; $display("FAIL b2b_ptr1 got %0h want 100000", ev_ptr[n0+1]); end
    end
    n_tests++; if (front_buf !== 1'b1) begin n_fail++; $display("FAIL b2b_front got %0h want 1", front_buf); end
  endtask

  task automatic test_ack_delay();
    int n0, s0, g0, cyc;
    bit ok;
    ack_mode = 1; n0 = ev_cmd.size(); s0 = stab_err; g0 = gap_err;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; cyc = i + 1; break; end
    end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL delay_init_done got %0d want 1", ok); end
    n_tests++; if (cyc !== 56) begin n_fail++; $display("FAIL delay_init_cycles got %0d want 56", cyc); end
    n_tests++; if (ev_cmd.size() !== n0 + 8) begin n_fail++; $display("FAIL delay_event_count got %0d want 8", ev_cmd.size() - n0); end
    if (ev_cmd.size() >= n0 + 8) begin
      for (int i = 0; i < 8; i++) begin
        n_tests++; if (ev_cmd[n0+i] !== init_cmds[i] || ev_ptr[n0+i] !== init_ptrs[i]) begin
          n_fail++; $display("FAIL delay_event[%0d] got %0h/%0h want %0h/%0h", i, ev_cmd[n0+i], ev_ptr[n0+i], init_cmds[i], init_ptrs[i]);
        end
      end
    end
    n0 = ev_cmd.size();
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    repeat (12) @(negedge clk);
    n_tests++; if (ev_cmd.size() !== n0 + 1) begin n_fail++; $display("FAIL delay_flip_count got %0d want 1", ev_cmd.size() - n0); end
    else begin
      n_tests++; if (ev_ptr[n0] !== 40'h100000) begin n_fail++; $display("FAIL delay_flip_ptr got %0h want 100000", ev_ptr[n0]); end
    end
    n_tests++; if (stab_err !== s0) begin n_fail++; $display("FAIL delay_stable got %0d want %0d", stab_err, s0); end
    n_tests++; if (gap_err !== g0) begin n_fail++; $display("FAIL delay_gap got %0d want %0d", gap_err, g0); end
    n_tests++; if (err !== 1'b0 || front_buf !== 1'b1) begin n_fail++; $display("FAIL delay_state got err=%0h front=%0h want err=0 front=1", err, front_buf); end
  endtask

  task automatic test_timeout();
    int n0, f0, hi;
    bit ok;
    ack_mode = 2; n0 = ev_cmd.size(); f0 = n_fack;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    ok = 1'b0; hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) begin ok = 1'b1; break; end
      hi += int'(bus.eve_stb);
    end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %0d want 1", ok); end
    n_tests++; if (hi !== 255) begin n_fail++; $display("FAIL timeout_wait_cycles got %0d want 255", hi); end
    n_tests++; if (bus.eve_stb !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_outputs got stb=%0h busy=%0h want stb=0 busy=1", bus.eve_stb, busy); end
    n_tests++; if (front_buf !== 1'b1 || n_fack !== f0) begin n_fail++; $display("FAIL timeout_no_flip got front=%0h acks=%0d want front=1 acks=%0d", front_buf, n_fack, f0); end
    ack_mode = 0;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.eve_stb !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL err_hold got stb=%0h err=%0h want stb=0 err=1", bus.eve_stb, err); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (err !== 1'b0 || front_buf !== 1'b0) begin n_fail++; $display("FAIL restart_clear got err=%0h front=%0h want 0/0", err, front_buf); end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (6) @(negedge clk);
    n_tests++; if (ok !== 1'b1 || ev_cmd.size() !== n0 + 8) begin n_fail++; $display("FAIL rerun_init got done=%0d events=%0d want 1/8", ok, ev_cmd.size() - n0); end
    if (ev_cmd.size() >= n0 + 8) begin
      for (int i = 0; i < 8; i++) begin
        n_tests++; if (ev_cmd[n0+i] !== init_cmds[i]) begin n_fail++; $display("FAIL rerun_cmd[%0d] got %0h want %0h", i, ev_cmd[n0+i], init_cmds[i]); end
      end
    end
  endtask

  task automatic test_init_flips();
    int n0, f0;
    ack_mode = 0; n0 = ev_cmd.size(); f0 = n_fack;
    start = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      start    = (k == 3);
      flip_req = (k == 2) || (k == 5);
    end
    start = 1'b0; flip_req = 1'b0;
    n_tests++; if (ev_cmd.size() !== n0 + 9) begin n_fail++; $display("FAIL init_flip_events got %0d want 9", ev_cmd.size() - n0); end
    else begin
      n_tests++; if (ev_cmd[n0+8] !== 8'h20 || ev_ptr[n0+8] !== 40'h100000) begin n_fail++; $display("FAIL init_flip_event got %0h/%0h want 20/100000", ev_cmd[n0+8], ev_ptr[n0+8]); end
    end
    n_tests++; if (n_fack - f0 !== 1) begin n_fail++; $display("FAIL init_flip_acks got %0d want 1", n_fack - f0); end
    n_tests++; if (front_buf !== 1'b1) begin n_fail++; $display("FAIL init_flip_front got %0h want 1", front_buf); end
  endtask

  task automatic test_soft_rst();
    int n0, f0;
    ack_mode = 2; f0 = n_fack;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.eve_stb !== 1'b1) begin n_fail++; $display("FAIL srst_pre_stb got %0h want 1", bus.eve_stb); end
    soft_rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.eve_stb !== 1'b0) begin n_fail++; $display("FAIL srst_stb got %0h want 0", bus.eve_stb); end
    n_tests++; if (front_buf !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL srst_state got front=%0h busy=%0h want 0/1", front_buf, busy); end
    @(negedge clk);
    soft_rst = 1'b0;
    ack_mode = 0; n0 = ev_cmd.size();
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (n_fack !== f0) begin n_fail++; $display("FAIL srst_no_ack got %0d want %0d", n_fack, f0); end
    n_tests++; if (ev_cmd.size() !== n0 || bus.eve_stb !== 1'b0) begin n_fail++; $display("FAIL srst_idle got events=%0d stb=%0h want 0/0", ev_cmd.size() - n0, bus.eve_stb); end
    n_tests++; if (back_addr !== 39'h100000 || err !== 1'b0) begin n_fail++; $display("FAIL srst_back got %0h err=%0h want 100000 err=0", back_addr, err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_flips();
    test_back_to_back();
    test_ack_delay();
    test_timeout();
    test_init_flips();
    test_soft_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rbus_vo_flip_ctrl.md
# rbus_vo_flip_ctrl

Configuration and page-flip sequencer for the ring-bus video-out device. On `start` it issues the full configuration sequence over the ring event interface: physical width, logical width/height, mode, sync polarities, text disable, base address. It then serves double-buffer flip requests by issuing base-address events that alternate between two frame buffers. It sits beside the renderer, driving event commands addressed to the video-out device.

## Interface
Parameters:
- `EVE_DEV`, 8'h00: destination device id placed on `eve_dev`
- `BUF0_ADDR`, 39'h000000000: frame buffer 0 base address
- `BUF1_ADDR`, 39'h000100000: frame buffer 1 base address
- `PH_WIDTH`, 16'd2048: physical line width
- `LO_WIDTH`, 16'd480: logical width
- `LO_HEIGHT`, 16'd272: logical height
- `MODE`, 2'b00: pixel mode (RGBA)
- `H_POL`, 1'b0: hsync polarity
- `V_POL`, 1'b0: vsync polarity
- `ACK_TIMEOUT`, 8'd255: maximum cycles `eve_stb` may wait for `eve_ack`

Ports:
- `clk`, in, 1: clock; the block uses a single clock
- `rst`, in, 1: reset, synchronous and active-high
- `soft_rst`, in, 1: synchronous soft reset, same effect as `rst`
- `start`, in, 1: pulse that starts the configuration sequence
- `flip_req`, in, 1: pulse requesting a buffer flip
- `flip_ack`, out, 1: one-cycle pulse when the flip event has been acknowledged
- `busy`, out, 1: high while in INIT or ERR, or before the first init completes
- `front_buf`, out, 1: index of the buffer currently displayed
- `back_addr`, out, 39: base address of the buffer the renderer may draw into
- `err`, out, 1: high when an acknowledge timeout has occurred (sticky)
- `eve_stb`, out, 1: event strobe
- `eve_cmd`, out, 8: event command
- `eve_dev`, out, 8: destination device, constant `EVE_DEV`
- `eve_ptr`, out, 40: event argument
- `eve_ack`, in, 1: event acknowledge

## Operation
- States: IDLE, INIT, READY, FLIP, ERR.
- IDLE: entered after reset. `busy`=1. `start` moves to INIT with step=0.
- INIT issues 8 events in this fixed order, with `eve_ptr` zero-extended to 40 bits:
  - 0x21 `PH_WIDTH`
  - 0x22 `LO_WIDTH`
  - 0x23 `LO_HEIGHT`
  - 0x24 `MODE`
  - 0x27 `H_POL`
  - 0x28 `V_POL`
  - 0x25 with ptr 0
  - 0x20 {1'b0,`BUF0_ADDR`}
- After the last ack: `front_buf`=0 and the state moves to READY.
- Event handshake:
  - `eve_stb` is held high with `eve_cmd` and `eve_ptr` stable until a cycle in which `eve_stb && eve_ack`.
  - `eve_stb` is low for exactly one cycle after each accepted event.
  - `eve_ack` while `eve_stb`=0 is ignored.
- Timeout:
  - An 8-bit counter increments each cycle with `eve_stb`=1 and `eve_ack`=0, and clears on accept.
  - When the counter reaches `ACK_TIMEOUT`, the block drops `eve_stb`, sets `err`=1 and enters ERR.
- `flip_req` is latched into a single pending bit in any state except IDLE and ERR. Multiple pulses merge into one flip.
- READY with a pending flip:
  - Enter FLIP and issue 0x20 with ptr {1'b0, back-buffer address}.
  - On ack: toggle `front_buf`, clear pending, pulse `flip_ack`, return to READY.
  - A `flip_req` in the same cycle as the ack re-sets pending.
- `start` in READY or ERR:
  - Clears `err`, clears pending, resets `front_buf` to 0 and enters INIT.
  - `start` is ignored in INIT and FLIP.
- ERR: `busy`=1, `eve_stb`=0. Exit only via `start`, `rst` or `soft_rst`.
- `back_addr` = `front_buf` ? `BUF0_ADDR` : `BUF1_ADDR`. It is combinational from `front_buf`.

## Timing
- Reset values:
  - state IDLE
  - `eve_stb`=0, `eve_cmd`=0, `eve_ptr`=0
  - `flip_ack`=0, `err`=0, `front_buf`=0, `busy`=1
  - pending=0, step=0, timeout counter=0
  - `eve_dev`=`EVE_DEV`
- Reset asserted mid-event drops `eve_stb` on the next cycle; no further events are issued.
- `start` sampled at cycle 0 gives `eve_stb` at cycle 1. With immediate ack, event k is strobed at cycle 1+2k. The last event is at cycle 15, and `busy` falls at cycle 16 (state READY).
- Flip with immediate ack:
  - `flip_req` at cycle n (in READY) gives `eve_stb` at n+2.
  - `flip_ack` and the `front_buf` toggle appear at n+3.
  - Earliest next flip strobe is n+5.
- All outputs are registered except `back_addr`.

## Test plan
- Reset, then `start` with `eve_ack` tied to `eve_stb` -> 8 events in the order 21,22,23,24,27,28,25,20 with ptrs 2048,480,272,0,0,0,0,0. `busy` low at cycle 16.
- After init, three `flip_req` pulses spaced 10 cycles apart -> ptrs 0x100000, 0x0, 0x100000. `flip_ack` pulses 3. Final `front_buf`=1 and `back_addr`=0x0.
- `eve_ack` delayed 5 cycles per event -> each event's cmd/ptr stable during the wait, a one-cycle gap between events, no missed or duplicated event.
- `eve_ack` never asserted -> `err`=1 after 255 waiting cycles, `eve_stb`=0. Then `start` with ack -> `err` clears and the full init reruns.
- Two `flip_req` pulses during INIT -> exactly one flip event after init, one `flip_ack`.
- `soft_rst` asserted while a flip event is waiting for ack -> `eve_stb` low the next cycle, state IDLE, `front_buf`=0, no `flip_ack`.
